debounce_fsm_amisha: RTL and testbench
======================================

# debounce_fsm_amisha

Switch/button debouncer that consumes the periodic max tick produced by the team's free-running binary counter and uses it as a sampling enable. A raw, asynchronous switch input is synchronized and must hold a new level for a programmable number of consecutive ticks before the debounced level changes. One-clock rise and fall pulses are produced for downstream edge-driven logic, such as a counter enable or a stopwatch start/stop.

## Interface
- N_TICKS_amisha, default 3: consecutive ticks of a stable new level required to accept a change; legal range is 1 or more.
- CNT_W_amisha, default 2: width of the internal tick counter; must satisfy 2**CNT_W_amisha >= N_TICKS_amisha.
- clk_amisha, input, 1: single system clock; all state updates on its rising edge.
- reset_amisha, input, 1: asynchronous, active-high reset.
- sw_amisha, input, 1: raw switch level; asynchronous to the clock and possibly bouncing.
- m_tick_amisha, input, 1: sampling enable, one clock wide; normally the counter's max tick.
- db_level_amisha, output, 1: debounced level.
- db_rise_tick_amisha, output, 1: one-clock pulse when db_level_amisha goes 0→1.
- db_fall_tick_amisha, output, 1: one-clock pulse when db_level_amisha goes 1→0.

## Operation
- **Synchronizer:** sw_amisha passes through a 2-flop synchronizer, reset to 0. Its output sw_s is the only version of the switch the FSM sees.
- **State and counter:** four states, ZERO, WAIT1, ONE and WAIT0, plus counter cnt[CNT_W_amisha-1:0].
- **ZERO:**
  - If sw_s=1, go to WAIT1 and set cnt to 0.
  - m_tick_amisha in this cycle is ignored.
- **WAIT1:**
  - If sw_s=0, go back to ZERO (abort).
  - Otherwise, on m_tick_amisha with cnt=N_TICKS_amisha-1, go to ONE.
  - Otherwise, on m_tick_amisha, increment cnt.
  - Otherwise, hold.
- **ONE:** if sw_s=0, go to WAIT0 and set cnt to 0.
- **WAIT0:** mirrors WAIT1 with the levels inverted. sw_s=1 aborts back to ONE; the final tick goes to ZERO.
- **Abort priority:** an abort beats a qualifying tick in the same cycle.
- **db_level_amisha:** registered; equals 1 exactly when the state is ONE or WAIT0.
- **db_rise_tick_amisha:** registered; high for exactly the first clock spent in ONE after arriving from WAIT1.
- **db_fall_tick_amisha:** registered; high for exactly the first clock spent in ZERO after arriving from WAIT0.
- **Aborts produce no edge pulses:** WAIT1→ZERO and WAIT0→ONE never generate a tick.
- **Pulse exclusivity:** the rise and fall ticks are never high together, and each is at most one cycle long.
- **Counter arithmetic:** cnt never exceeds N_TICKS_amisha-1, so no wrap is possible.
- **N_TICKS_amisha=1:** the first tick seen in a WAIT state completes the transition.
- **m_tick_amisha held high continuously (degenerate):** the block still behaves correctly and counts one tick per clock.
- **Reset:** state ZERO, cnt 0, synchronizer flops 0, and all three outputs 0.
  - Applies immediately and asynchronously, including mid-WAIT or while in ONE.
  - db_level_amisha drops to 0 with no fall tick.
  - After release, the FSM starts in ZERO. A switch already held high must qualify again through WAIT1.

## Timing
- **Synchronizer latency:** sw_s follows sw_amisha after 2 clock edges.
- **Entering WAIT:** the state becomes WAIT1/WAIT0 on the edge after sw_s changes, which is 3 edges after sw_amisha.
- **Leaving WAIT:** the transition to ONE/ZERO happens on the edge that samples the N_TICKS_amisha-th tick seen while in WAIT.
- **Output timing:** db_level_amisha and the matching edge tick change on that same edge; all outputs are registered with no combinational path from the inputs.
- **Worst-case acceptance latency:** tick period P means at most 3 + N_TICKS_amisha·P clocks. The bound is 15 clocks for N_TICKS_amisha=3, P=4.
- **Minimum sustained stability:** a new level needs roughly (N_TICKS_amisha-1)·P clocks; shorter pulses are rejected.

## Test plan
All scenarios use N_TICKS_amisha=3 and m_tick_amisha high one clock in every 4, at cycles 3, 7, 11, … after reset release.

1. Reset with sw_amisha=1 held → all outputs 0 during reset. After release, db_level_amisha rises no earlier than the 3rd tick after WAIT1 entry, with exactly one db_rise_tick_amisha.
2. Clean rise: sw_amisha goes 0→1 at cycle 20 and is held → WAIT1 from cycle 23. db_level_amisha=1 and db_rise_tick_amisha=1 after the tick at cycle 35, and the rise tick is gone the next cycle.
3. Bounce: sw_amisha=1 for 5 clocks spanning one tick, then 0 → db_level_amisha stays 0, no ticks are produced, and the FSM returns to ZERO.
4. Clean fall from ONE: sw_amisha goes 1→0 and is held for 3 ticks → db_level_amisha=0 and db_fall_tick_amisha is high for exactly one cycle.
5. Simultaneous events: in WAIT1 with cnt=2, sw_s drops in the same cycle as m_tick_amisha → abort to ZERO, with no rise and no level change.
6. Reset mid-WAIT0 while db_level_amisha=1 → db_level_amisha=0 immediately, with no db_fall_tick_amisha before or after reset release.

Source files
------------

// File: rtl/debounce_fsm_amisha.sv
// debounce_fsm_amisha: switch debouncer driven by a periodic sampling tick.
// The raw switch is synchronized, and a new level must stay stable for
// N_TICKS_amisha consecutive ticks before the debounced level follows it.
// One-clock rise/fall pulses mark each accepted change. Aborted attempts
// never produce a pulse.
module debounce_fsm_amisha #(
  parameter int unsigned N_TICKS_amisha = 3,
  parameter int unsigned CNT_W_amisha   = 2
) (
  input  logic clk_amisha,
  input  logic reset_amisha,
  input  logic sw_amisha,
  input  logic m_tick_amisha,
  output logic db_level_amisha,
  output logic db_rise_tick_amisha,
  output logic db_fall_tick_amisha
);

  // Two stable levels, each with a qualifying wait state toward the other level.
  localparam logic [1:0] StZero  = 2'd0;
  localparam logic [1:0] StWait1 = 2'd1;
  localparam logic [1:0] StOne   = 2'd2;
  localparam logic [1:0] StWait0 = 2'd3;

  // Terminal count: the tick seen while cnt holds this value completes a wait.
  localparam logic [CNT_W_amisha-1:0] CntLast = CNT_W_amisha'(N_TICKS_amisha - 1);
  localparam logic [CNT_W_amisha-1:0] CntOne  = CNT_W_amisha'(1);

  logic                    sw_meta_q;
  logic                    sw_s_q;
  logic [1:0]              state_q, state_d;
  logic [CNT_W_amisha-1:0] cnt_q, cnt_d;
  logic                    level_q, level_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic                    last_tick;

  // Two-flop synchronizer. sw_s_q is the only copy of the switch seen by the FSM.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      sw_meta_q <= 1'b0;
      sw_s_q    <= 1'b0;
    end else begin
      sw_meta_q <= sw_amisha;
      sw_s_q    <= sw_meta_q;
    end
  end

  assign last_tick = m_tick_amisha && (cnt_q == CntLast);

  // Next-state and counter logic. Inside a wait state, an abort takes priority over a tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StZero: begin
        if (sw_s_q) begin
          state_d = StWait1;
          cnt_d   = '0;
        end
      end
      StWait1: begin
        if (!sw_s_q) begin
          state_d = StZero;
        end else if (last_tick) begin
          state_d = StOne;
        end else if (m_tick_amisha) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StOne: begin
        if (!sw_s_q) begin
          state_d = StWait0;
          cnt_d   = '0;
        end
      end
      StWait0: begin
        if (sw_s_q) begin
          state_d = StOne;
        end else if (last_tick) begin
          state_d = StZero;
        end else if (m_tick_amisha) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StZero;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs come from the next state, so they change on the same edge as the state.
  always_comb begin
    level_d = (state_d == StOne) || (state_d == StWait0);
    rise_d  = (state_q == StWait1) && (state_d == StOne);
    fall_d  = (state_q == StWait0) && (state_d == StZero);
  end

  // FSM state, tick counter and output registers.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state_q <= StZero;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_level_amisha     = level_q;
  assign db_rise_tick_amisha = rise_q;
  assign db_fall_tick_amisha = fall_q;

endmodule

// File: tb/tb_debounce_fsm_amisha.sv
// Bench for debounce_fsm_amisha: the driver pushes expected outputs from a
// level/stability reference model, and a monitor pops and compares each cycle.
module tb_debounce_fsm_amisha;

  localparam int unsigned N = 3;

  logic clk_amisha = 1'b0;
  logic reset_amisha;
  logic sw_amisha;
  logic m_tick_amisha;
  logic db_level_amisha;
  logic db_rise_tick_amisha;
  logic db_fall_tick_amisha;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tick_mode = 0;

  // Reference model: delayed switch copies, and how long the level has differed.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  logic m_pend = 1'b0;
  int   m_ticks = 0;
  logic [2:0] sb[$];

  debounce_fsm_amisha #(
    .N_TICKS_amisha(N),
    .CNT_W_amisha  (2)
  ) dut (
    .clk_amisha         (clk_amisha),
    .reset_amisha       (reset_amisha),
    .sw_amisha          (sw_amisha),
    .m_tick_amisha      (m_tick_amisha),
    .db_level_amisha    (db_level_amisha),
    .db_rise_tick_amisha(db_rise_tick_amisha),
    .db_fall_tick_amisha(db_fall_tick_amisha)
  );

  always #5 clk_amisha = ~clk_amisha;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // A change is accepted once the synchronized switch has differed from the
  // debounced level for N sampling ticks. The tick in the first differing
  // cycle does not count, and any return to the current level restarts the count.
  task automatic model_step(input logic r, input logic s, input logic t);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (r) begin
      m_level = 1'b0; m_pend = 1'b0; m_ticks = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      if (m_s2 == m_level) begin
        m_pend = 1'b0;
        m_ticks = 0;
      end else if (!m_pend) begin
        m_pend = 1'b1;
        m_ticks = 0;
      end else if (t) begin
        m_ticks++;
        if (m_ticks == N) begin
          m_level = m_s2;
          m_rise  = m_s2;
          m_fall  = !m_s2;
          m_pend  = 1'b0;
          m_ticks = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = s;
    end
    sb.push_back({m_level, m_rise, m_fall});
  endtask

  task automatic step(input logic r, input logic s);
    logic t;
    @(negedge clk_amisha);
    if (r) cyc = 0;
    case (tick_mode)
      0:       t = (cyc % 4 == 3);
      1:       t = 1'b1;
      default: t = ($urandom_range(3) == 0);
    endcase
    reset_amisha  = r;
    sw_amisha     = s;
    m_tick_amisha = t;
    model_step(r, s, t);
    if (!r) cyc++;
  endtask

  // Monitor: every clock presents an output, so each cycle pops one expectation.
  initial begin
    logic [2:0] exp;
    forever begin
      @(posedge clk_amisha);
      #1;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("db_level", db_level_amisha, exp[2]);
        check("db_rise_tick", db_rise_tick_amisha, exp[1]);
        check("db_fall_tick", db_fall_tick_amisha, exp[0]);
        check("rise_fall_exclusive", db_rise_tick_amisha & db_fall_tick_amisha, 1'b0);
      end
    end
  end

  initial begin
    logic s;
    int   len;
    reset_amisha  = 1'b1;
    sw_amisha     = 1'b0;
    m_tick_amisha = 1'b0;
    tick_mode     = 0;

    // Reset with switch high, then it must qualify again after release.
    repeat (3) step(1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b1);

    // Clean rise at cycle 20.
    repeat (2) step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    repeat (25) step(1'b0, 1'b1);

    // Clean fall from ONE.
    repeat (25) step(1'b0, 1'b0);

    // Short bounce spanning one tick.
    repeat (5) step(1'b0, 1'b1);
    repeat (15) step(1'b0, 1'b0);

    // Sweep release points across the final tick of WAIT1, including an abort in the tick cycle.
    for (int d = 4; d < 16; d++) begin
      repeat (d) step(1'b0, 1'b1);
      repeat (20) step(1'b0, 1'b0);
    end

    // Reset while in WAIT0 with the level high: the level drops at once, with no fall pulse.
    repeat (25) step(1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    #1;
    check("async_reset_level", db_level_amisha, 1'b0);
    check("async_reset_fall", db_fall_tick_amisha, 1'b0);
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);

    // Random switch activity under periodic, continuous and random ticks.
    for (int mode = 0; mode < 3; mode++) begin
      tick_mode = mode;
      for (int k = 0; k < 60; k++) begin
        s   = 1'($urandom_range(1));
        len = $urandom_range(20, 1);
        if ($urandom_range(29) == 0) step(1'b1, s);
        repeat (len) step(1'b0, s);
      end
    end

    tick_mode = 0;
    repeat (4) step(1'b0, 1'b0);
    @(posedge clk_amisha);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
